// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//   Shared definitions for the system-bus arbiter:
//   - FSM state encodings (IDLE / OWNED)
//   - symbolic bus-master indices BUS_MASTER_0..7
//   - default master count and owner-index width
//   Imported by bus_arbiter and by anything that needs to name a master.
package bus_arbiter_pkg;

  typedef enum logic {
    BUS_ARB_STATE_IDLE  = 1'b0,  // no grant outstanding
    BUS_ARB_STATE_OWNED = 1'b1   // exactly one grant low
  } arb_state_e;

  localparam int BUS_MASTER_0 = 0;
  localparam int BUS_MASTER_1 = 1;
  localparam int BUS_MASTER_2 = 2;
  localparam int BUS_MASTER_3 = 3;
  localparam int BUS_MASTER_4 = 4;
  localparam int BUS_MASTER_5 = 5;
  localparam int BUS_MASTER_6 = 6;
  localparam int BUS_MASTER_7 = 7;

  localparam int BUS_ARB_NUM_MASTERS = 4;
  localparam int BUS_ARB_OWNER_W     = 2;

endpackage

// File: rtl/bus_arb_rr_pick.sv
// bus_arb_rr_pick
//   Combinational round-robin picker. Returns the first requesting index
//   at or after 'start', wrapping modulo NUM_MASTERS.
// Ports:
//   req    in   NUM_MASTERS  request vector, active high
//   start  in   OWNER_W      index searched first
//   winner out  OWNER_W      chosen index (valid only when found = 1)
//   found  out  1            at least one request present
module bus_arb_rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2
) (
  input  logic [NUM_MASTERS-1:0] req,
  input  logic [OWNER_W-1:0]     start,
  output logic [OWNER_W-1:0]     winner,
  output logic                   found
);

  logic [NUM_MASTERS-1:0] upper_mask;
  logic [NUM_MASTERS-1:0] upper_req;
  logic [NUM_MASTERS-1:0] sel;
  logic [NUM_MASTERS-1:0][OWNER_W-1:0] enc_chain;

  // Wrap-around search without modulo arithmetic: first look only at
  // indices >= start; if none request, the lowest request overall is the
  // wrapped winner.
  assign upper_req = req & upper_mask;
  assign sel       = (|upper_req) ? upper_req : req;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_bit
      assign upper_mask[gi] = (OWNER_W'(gi) >= start);
      if (gi == 0) begin : g_lsb
        // Index 0 encodes as all zeros, so it contributes nothing.
        assign enc_chain[gi] = '0;
      end else begin : g_upper
        logic first_bit;
        assign first_bit     = sel[gi] & ~(|sel[gi-1:0]);
        assign enc_chain[gi] = enc_chain[gi-1] | (first_bit ? OWNER_W'(gi) : '0);
      end
    end
  endgenerate

  assign winner = enc_chain[NUM_MASTERS-1];
  assign found  = |req;

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter for the shared system bus. Accepts active-low
//   requests from NUM_MASTERS masters and issues at most one registered
//   active-low grant. The owner keeps the bus until it drops its request;
//   on release the bus is handed to the next round-robin requester on the
//   same edge (no idle cycle).
// Optional feature (macro BUS_ARB_TIMEOUT_EN):
//   a tenure counter revokes the owner after HOLD_MAX cycles when another
//   master is waiting, pulsing arb_tmo for one cycle. Without the macro the
//   tenure is unbounded and arb_tmo is constant 0.
// Ports:
//   clk        in   1            system clock, rising edge
//   reset      in   1            asynchronous active-high reset
//   m_req_     in   NUM_MASTERS  requests, active low, bit i = master i
//   m_grnt_    out  NUM_MASTERS  grants, active low, registered, one-cold
//   owner      out  OWNER_W      current owner (valid when owner_vld)
//   owner_vld  out  1            a grant is asserted
//   arb_tmo    out  1            one-cycle pulse on a forced revoke
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = BUS_ARB_NUM_MASTERS,
  parameter int OWNER_W     = BUS_ARB_OWNER_W,
  parameter int HOLD_MAX    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] m_req_,
  output logic [NUM_MASTERS-1:0] m_grnt_,
  output logic [OWNER_W-1:0]     owner,
  output logic                   owner_vld,
  output logic                   arb_tmo
);

  generate
    if (NUM_MASTERS < 2 || NUM_MASTERS > 8 || OWNER_W != $clog2(NUM_MASTERS) || HOLD_MAX < 2)
    begin : g_bad_params
      $error("bus_arbiter: invalid parameterisation");
    end
  endgenerate

  localparam logic [OWNER_W-1:0] LAST_IDX = OWNER_W'(NUM_MASTERS - 1);

  arb_state_e             state_reg, state_next;
  logic [NUM_MASTERS-1:0] grnt_reg, grnt_next;
  logic [OWNER_W-1:0]     owner_reg, owner_next;
  logic [OWNER_W-1:0]     last_reg, last_next;
  logic                   vld_reg, vld_next;
  logic                   tmo_reg, tmo_next;

  logic [NUM_MASTERS-1:0] req;
  logic [NUM_MASTERS-1:0] owner_mask;
  logic [NUM_MASTERS-1:0] win_mask;
  logic [NUM_MASTERS-1:0] pick_req;
  logic [OWNER_W-1:0]     start;
  logic [OWNER_W-1:0]     winner;
  logic                   found;
  logic                   owner_req;
  logic                   timeout_hit;

  assign req = ~m_req_;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
      assign owner_mask[gi] = (owner_reg == OWNER_W'(gi));
      assign win_mask[gi]   = (winner == OWNER_W'(gi));
    end
  endgenerate

  assign owner_req = |(req & owner_mask);

  // While OWNED the owner is excluded, so a timeout revoke never re-picks
  // it and a released owner that re-requests at once ranks last.
  assign pick_req = (state_reg == BUS_ARB_STATE_OWNED) ? (req & ~owner_mask) : req;
  // last_reg equals owner_reg while OWNED, so one start index serves both paths.
  assign start    = (last_reg == LAST_IDX) ? '0 : last_reg + OWNER_W'(1);

  bus_arb_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .OWNER_W     (OWNER_W)
  ) u_pick (
    .req    (pick_req),
    .start  (start),
    .winner (winner),
    .found  (found)
  );

  always_comb begin
    state_next = state_reg;
    grnt_next  = grnt_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    vld_next   = vld_reg;
    tmo_next   = 1'b0;
    case (state_reg)
      BUS_ARB_STATE_IDLE: begin
        if (found) begin
          state_next = BUS_ARB_STATE_OWNED;
          grnt_next  = ~win_mask;
          owner_next = winner;
          last_next  = winner;
          vld_next   = 1'b1;
        end
      end
      BUS_ARB_STATE_OWNED: begin
        if (!owner_req || timeout_hit) begin
          if (found) begin
            // Old grant rises and new grant falls on the same edge.
            grnt_next  = ~win_mask;
            owner_next = winner;
            last_next  = winner;
            tmo_next   = owner_req;  // still requesting => forced revoke
          end else if (!owner_req) begin
            state_next = BUS_ARB_STATE_IDLE;
            grnt_next  = '1;
            vld_next   = 1'b0;
          end
        end
      end
      default: begin
        state_next = BUS_ARB_STATE_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= BUS_ARB_STATE_IDLE;
      grnt_reg  <= '1;
      owner_reg <= OWNER_W'(BUS_MASTER_0);
      last_reg  <= LAST_IDX;
      vld_reg   <= 1'b0;
      tmo_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      grnt_reg  <= grnt_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      vld_reg   <= vld_next;
      tmo_reg   <= tmo_next;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(HOLD_MAX);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic             new_grant;

  // Every new grant changes the grant vector (IDLE->OWNED or a handover
  // to a different master), which is cheaper than tracking it separately.
  assign new_grant   = (state_next == BUS_ARB_STATE_OWNED) && (grnt_next != grnt_reg);
  assign timeout_hit = (state_reg == BUS_ARB_STATE_OWNED) && (cnt_reg == CNT_LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (new_grant) begin
      cnt_reg <= '0;
    end else if (state_reg == BUS_ARB_STATE_OWNED && cnt_reg != CNT_LIMIT) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  assign m_grnt_   = grnt_reg;
  assign owner     = owner_reg;
  assign owner_vld = vld_reg;
  assign arb_tmo   = tmo_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//   Directed bench for bus_arbiter (4 masters, HOLD_MAX = 8). A
//   transaction-level model tracks owner / last owner / tenure as integers
//   and is compared against the DUT every cycle; directed steps also check
//   hand-computed literal values. Define BUS_ARB_TIMEOUT_EN to exercise
//   the revoke path instead of unbounded tenure.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  localparam int N    = 4;
  localparam int W    = 2;
  localparam int HOLD = 8;

  logic         clk;
  logic         rst;
  logic [N-1:0] m_req_;
  logic [N-1:0] m_grnt_;
  logic [W-1:0] owner;
  logic         owner_vld;
  logic         arb_tmo;

  int n_checks = 0;
  int n_fail   = 0;

  bus_arbiter #(
    .NUM_MASTERS (N),
    .OWNER_W     (W),
    .HOLD_MAX    (HOLD)
  ) dut (
    .clk       (clk),
    .reset     (rst),
    .m_req_    (m_req_),
    .m_grnt_   (m_grnt_),
    .owner     (owner),
    .owner_vld (owner_vld),
    .arb_tmo   (arb_tmo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mdl_owner = -1;       // -1 = no owner
  int mdl_last  = N - 1;
  int mdl_hold  = 0;        // OWNED cycles of the current tenure, 1-based
  bit mdl_tmo   = 1'b0;

  // First requester (active-low vector) at or after 'from', skipping 'excl'.
  function automatic int rr_search(input logic [N-1:0] req_n, input int from, input int excl);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (from + k) % N;
      if (c != excl && req_n[c] == 1'b0) return c;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    int w, o, l, h;
    bit t;
    if (rst) begin
      mdl_owner <= -1;
      mdl_last  <= N - 1;
      mdl_hold  <= 0;
      mdl_tmo   <= 1'b0;
    end else begin
      o = mdl_owner; l = mdl_last; h = mdl_hold; t = 1'b0;
      if (o < 0) begin
        w = rr_search(m_req_, l + 1, -1);
        if (w >= 0) begin o = w; l = w; h = 1; end
      end else if (m_req_[o] == 1'b1) begin
        w = rr_search(m_req_, o + 1, o);
        if (w >= 0) begin o = w; l = w; h = 1; end
        else o = -1;
      end else begin
`ifdef BUS_ARB_TIMEOUT_EN
        w = rr_search(m_req_, o + 1, o);
        if (h >= HOLD && w >= 0) begin o = w; l = w; h = 1; t = 1'b1; end
        else h = h + 1;
`else
        h = h + 1;
`endif
      end
      mdl_owner <= o;
      mdl_last  <= l;
      mdl_hold  <= h;
      mdl_tmo   <= t;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] exp_g;
    exp_g = '1;
    if (mdl_owner >= 0) exp_g[mdl_owner] = 1'b0;
    chk("model_grnt", m_grnt_, exp_g);
    chk("model_vld", owner_vld, (mdl_owner >= 0) ? 1 : 0);
    chk("model_tmo", arb_tmo, mdl_tmo);
    chk("onehot0", $onehot0(~m_grnt_), 1);
    if (mdl_owner >= 0) chk("model_owner", owner, mdl_owner);
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_lit(input string name, input logic [N-1:0] g, input logic v,
                         input int o, input logic t);
    $display("step %-14s req=%b grnt=%b owner=%0d vld=%b tmo=%b",
             name, m_req_, m_grnt_, owner, owner_vld, arb_tmo);
    chk({name, "_grnt"}, m_grnt_, g);
    chk({name, "_vld"}, owner_vld, v);
    if (v) chk({name, "_owner"}, owner, o);
    chk({name, "_tmo"}, arb_tmo, t);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst    = 1'b1;
    m_req_ = '1;
    cyc();
    cyc();
    chk_lit("reset", 4'b1111, 1'b0, 0, 1'b0);
    chk("reset_owner0", owner, 0);
    rst = 1'b0;

    // Single request, one-cycle latency.
    m_req_ = 4'b1110;
    cyc();
    chk_lit("first_grant", 4'b1110, 1'b1, BUS_MASTER_0, 1'b0);
    m_req_ = 4'b1111;
    cyc();
    chk_lit("first_release", 4'b1111, 1'b0, 0, 1'b0);

    // All request from reset; rotate 0,1,2,3,0 with zero-gap handover.
    do_reset();
    m_req_ = 4'b0000;
    cyc();
    chk_lit("all_req", 4'b1110, 1'b1, BUS_MASTER_0, 1'b0);
    for (int i = 0; i < N; i++) begin
      int nx;
      logic [N-1:0] g;
      nx = (i + 1) % N;
      cyc();
      cyc();
      m_req_[i] = 1'b1;
      cyc();
      g = '1;
      g[nx] = 1'b0;
      chk_lit($sformatf("rot_%0d_to_%0d", i, nx), g, 1'b1, nx, 1'b0);
      m_req_[i] = 1'b0;
    end
    m_req_ = 4'b1111;
    cyc();
    chk_lit("rot_idle", 4'b1111, 1'b0, 0, 1'b0);

    // Owner 2 holds while 1 and 3 wait; release goes to 3, then 1.
    do_reset();
    m_req_ = 4'b1011;
    cyc();
    chk_lit("own2", 4'b1011, 1'b1, BUS_MASTER_2, 1'b0);
    m_req_ = 4'b0001;
    cyc();
    chk_lit("own2_hold", 4'b1011, 1'b1, BUS_MASTER_2, 1'b0);
    m_req_ = 4'b0101;
    cyc();
    chk_lit("own2_to3", 4'b0111, 1'b1, BUS_MASTER_3, 1'b0);
    m_req_ = 4'b1101;
    cyc();
    chk_lit("own3_to1", 4'b1101, 1'b1, BUS_MASTER_1, 1'b0);
    m_req_ = 4'b1111;
    cyc();
    chk_lit("own1_idle", 4'b1111, 1'b0, 0, 1'b0);

    // Lone master 1: release to IDLE, re-request granted after one cycle.
    m_req_ = 4'b1101;
    cyc();
    chk_lit("lone1", 4'b1101, 1'b1, BUS_MASTER_1, 1'b0);
    m_req_ = 4'b1111;
    cyc();
    chk_lit("lone1_idle", 4'b1111, 1'b0, 0, 1'b0);
    m_req_ = 4'b1101;
    cyc();
    chk_lit("lone1_again", 4'b1101, 1'b1, BUS_MASTER_1, 1'b0);
    m_req_ = 4'b1111;
    cyc();

    // Asynchronous reset while master 3 owns; pointer restored.
    m_req_ = 4'b0111;
    cyc();
    chk_lit("own3", 4'b0111, 1'b1, BUS_MASTER_3, 1'b0);
    rst = 1'b1;
    #1;
    chk_lit("async_rst", 4'b1111, 1'b0, 0, 1'b0);
    m_req_ = 4'b0110;
    cyc();
    rst = 1'b0;
    cyc();
    chk_lit("post_rst_0", 4'b1110, 1'b1, BUS_MASTER_0, 1'b0);
    m_req_ = 4'b1111;
    cyc();

`ifdef BUS_ARB_TIMEOUT_EN
    // Master 0 hogs while 1 waits: revoke after the 8th OWNED cycle.
    do_reset();
    m_req_ = 4'b1110;
    cyc();
    chk_lit("tmo_grant0", 4'b1110, 1'b1, BUS_MASTER_0, 1'b0);
    m_req_ = 4'b1100;
    for (int k = 2; k <= HOLD; k++) begin
      cyc();
      chk_lit($sformatf("tmo_hold_%0d", k), 4'b1110, 1'b1, BUS_MASTER_0, 1'b0);
    end
    cyc();
    chk_lit("tmo_revoke", 4'b1101, 1'b1, BUS_MASTER_1, 1'b1);
    cyc();
    chk_lit("tmo_pulse_end", 4'b1101, 1'b1, BUS_MASTER_1, 1'b0);
    m_req_ = 4'b1111;
    cyc();
`endif

    // Master 0 alone past HOLD_MAX (timeout build) or with 1 waiting
    // (default build): tenure continues, no pulse.
    do_reset();
    m_req_ = 4'b1110;
    cyc();
`ifndef BUS_ARB_TIMEOUT_EN
    m_req_ = 4'b1100;
`endif
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk_lit($sformatf("long_hold_%0d", k), 4'b1110, 1'b1, BUS_MASTER_0, 1'b0);
    end
    m_req_ = 4'b1111;
    cyc();
    chk_lit("final_idle", 4'b1111, 1'b0, 0, 1'b0);
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
